// File: rtl/decode_pkg.sv
// Shared RV32I decode types: opcodes, ALU codes, immediate formats, decoded bundle.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package decode_pkg;

  localparam int ALU_CODE_W = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [ALU_CODE_W-1:0] {
    ALU_ADD  = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3,
    ALU_SLTU = 5'd4, ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7,
    ALU_OR   = 5'd8, ALU_AND = 5'd9
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  // Immediate is kept at 32 bits here; the stage sign-extends it to XLEN.
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_size;
    logic        reg_write;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  branch_cond;
    logic        illegal;
  } dec_bundle_t;

  // funct3 -> ALU code; alt (instr[30]) only matters for ADD/SUB and SRL/SRA.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Assemble a 32-bit sign-extended immediate from the instruction's upper bits.
  function automatic logic [31:0] imm_gen(input logic [31:7] w, input imm_fmt_e fmt);
    case (fmt)
      IMM_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
      IMM_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      IMM_U:   return {w[31:12], 12'b0};
      IMM_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return {{20{w[31]}}, w[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// Combinational RV32I instruction decoder: instr -> control bundle plus source-use flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage owns flow control.
module instr_decoder
  import decode_pkg::*;
(
  input  logic [31:0]  instr_i,
  output dec_bundle_t  dec_o,
  output logic         uses_rs1_o,
  output logic         uses_rs2_o
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  dec_bundle_t d;
  imm_fmt_e    fmt;
  logic        has_imm, use1, use2, wr, ill;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];

  // Per-opcode control decode; illegal encodings strip every side-effecting flag.
  always_comb begin
    d       = '0;
    fmt     = IMM_I;
    has_imm = 1'b0;
    use1    = 1'b0;
    use2    = 1'b0;
    wr      = 1'b0;
    ill     = 1'b0;
    case (opcode)
      OP_R: begin
        use1 = 1'b1; use2 = 1'b1; wr = 1'b1;
        d.alu_op = alu_from_f3(f3, instr_i[30]);
        ill = !((f7 == F7_BASE) || ((f7 == F7_ALT) && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OP_IMM: begin
        use1 = 1'b1; wr = 1'b1; has_imm = 1'b1; d.alu_src_imm = 1'b1;
        d.alu_op = alu_from_f3(f3, (f3 == 3'b101) && instr_i[30]);
        if (f3 == 3'b001) ill = (f7 != F7_BASE);
        if (f3 == 3'b101) ill = (f7 != F7_BASE) && (f7 != F7_ALT);
      end
      OP_LOAD: begin
        use1 = 1'b1; wr = 1'b1; has_imm = 1'b1; d.alu_src_imm = 1'b1;
        d.mem_read = 1'b1; d.mem_size = f3;
        ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE: begin
        use1 = 1'b1; use2 = 1'b1; has_imm = 1'b1; fmt = IMM_S; d.alu_src_imm = 1'b1;
        d.mem_write = 1'b1; d.mem_size = f3;
        ill = (f3 > 3'b010);
      end
      OP_BRANCH: begin
        use1 = 1'b1; use2 = 1'b1; has_imm = 1'b1; fmt = IMM_B;
        d.alu_op = ALU_SUB; d.is_branch = 1'b1; d.branch_cond = f3;
        ill = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_JAL: begin
        wr = 1'b1; has_imm = 1'b1; fmt = IMM_J;
        d.is_jal = 1'b1; d.alu_src_pc = 1'b1; d.alu_src_imm = 1'b1;
      end
      OP_JALR: begin
        use1 = 1'b1; wr = 1'b1; has_imm = 1'b1; d.alu_src_imm = 1'b1; d.is_jalr = 1'b1;
        ill = (f3 != 3'b000);
      end
      OP_LUI: begin
        wr = 1'b1; has_imm = 1'b1; fmt = IMM_U; d.alu_src_imm = 1'b1;
      end
      OP_AUIPC: begin
        wr = 1'b1; has_imm = 1'b1; fmt = IMM_U; d.alu_src_imm = 1'b1; d.alu_src_pc = 1'b1;
      end
      default: ill = 1'b1;
    endcase

    if (instr_i == 32'd0 || instr_i[1:0] != 2'b11) ill = 1'b1;

    d.rs1       = use1 ? instr_i[19:15] : 5'd0;
    d.rs2       = use2 ? instr_i[24:20] : 5'd0;
    d.rd        = wr   ? instr_i[11:7]  : 5'd0;
    d.imm       = has_imm ? imm_gen(instr_i[31:7], fmt) : 32'd0;
    d.illegal   = ill;
    d.reg_write = wr && (d.rd != 5'd0) && !ill;
    if (ill) begin
      d.mem_read  = 1'b0;
      d.mem_write = 1'b0;
      d.is_branch = 1'b0;
      d.is_jal    = 1'b0;
      d.is_jalr   = 1'b0;
    end
    dec_o      = d;
    uses_rs1_o = use1;
    uses_rs2_o = use2;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage between fetch and execute, with load-use interlock and stall counter.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready drops while the held bundle is not taken or a load-use hazard exists; flush overrides both.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ALU_OP_W  = 5,
  parameter int HAZARD_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  input  logic [XLEN-1:0]     pc,
  input  logic                flush,
  input  logic                ex_mem_read,
  input  logic [4:0]          ex_rd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [4:0]          rd,
  output logic [XLEN-1:0]     imm,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_imm,
  output logic                alu_src_pc,
  output logic                mem_read,
  output logic                mem_write,
  output logic [2:0]          mem_size,
  output logic                reg_write,
  output logic                is_branch,
  output logic                is_jal,
  output logic                is_jalr,
  output logic [2:0]          branch_cond,
  output logic                illegal,
  output logic [CNT_W-1:0]    stall_count
);

  dec_bundle_t      dec, bundle_q, bundle_d;
  logic             uses_rs1, uses_rs2, hazard, accept;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  instr_decoder u_instr_decoder (
    .instr_i    (instr),
    .dec_o      (dec),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2)
  );

  // Load-use interlock: hold the incoming instruction while a load in EX still owes one of its sources.
  always_comb begin
    hazard = 1'b0;
    if (HAZARD_EN != 0) begin
      hazard = in_valid && ex_mem_read && (ex_rd != 5'd0) &&
               ((uses_rs1 && dec.rs1 == ex_rd) || (uses_rs2 && dec.rs2 == ex_rd));
    end
  end

  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready && !flush;

  // Next state: flush kills, accept loads, a consumed bundle with nothing behind it empties the stage.
  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    if (hazard && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      bundle_d    = dec;
      pc_d        = pc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pipeline register and stall counter with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      pc_q        <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = pc_q;
  assign rs1         = bundle_q.rs1;
  assign rs2         = bundle_q.rs2;
  assign rd          = bundle_q.rd;
  assign imm         = XLEN'($signed(bundle_q.imm));
  assign alu_op      = ALU_OP_W'(bundle_q.alu_op);
  assign alu_src_imm = bundle_q.alu_src_imm;
  assign alu_src_pc  = bundle_q.alu_src_pc;
  assign mem_read    = bundle_q.mem_read;
  assign mem_write   = bundle_q.mem_write;
  assign mem_size    = bundle_q.mem_size;
  assign reg_write   = bundle_q.reg_write;
  assign is_branch   = bundle_q.is_branch;
  assign is_jal      = bundle_q.is_jal;
  assign is_jalr     = bundle_q.is_jalr;
  assign branch_cond = bundle_q.branch_cond;
  assign illegal     = bundle_q.illegal;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vectors, literal expectations and a cycle model of the stage.
// Latency: model tracks the 1-cycle accept-to-valid pipeline.
// Backpressure: stimulus exercises out_ready stalls, load-use stalls and flush.
module tb_decode_stage;

  localparam int XLEN = 32;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, flush, ex_mem_read, out_valid, out_ready;
  logic [31:0] instr;
  logic [XLEN-1:0] pc, out_pc, imm;
  logic [4:0] ex_rd, rs1, rs2, rd, alu_op;
  logic alu_src_imm, alu_src_pc, mem_read, mem_write, reg_write;
  logic is_branch, is_jal, is_jalr, illegal;
  logic [2:0] mem_size, branch_cond;
  logic [CNT_W-1:0] stall_count;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .ALU_OP_W(5), .HAZARD_EN(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
    .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .alu_src_pc(alu_src_pc), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .reg_write(reg_write), .is_branch(is_branch),
    .is_jal(is_jal), .is_jalr(is_jalr), .branch_cond(branch_cond), .illegal(illegal),
    .stall_count(stall_count)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic [31:0] imm;
    logic [4:0] alu;
    logic si, sp, mr, mw;
    logic [2:0] msz;
    logic rw, br, jal, jalr;
    logic [2:0] bc;
    logic ill, u1, u2;
  } mexp_t;

  function automatic mexp_t ref_decode(input logic [31:0] w);
    mexp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    int base [8];
    int alu;
    base = '{0, 2, 3, 4, 5, 6, 8, 9};
    e = '0;
    f3 = w[14:12];
    f7 = w[31:25];
    alu = 0;
    case (w[6:0])
      7'h33: begin
        e.u1 = 1; e.u2 = 1; e.rd = w[11:7];
        alu = base[f3] + ((w[30] && (f3 == 0 || f3 == 5)) ? 1 : 0);
        e.ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
      end
      7'h13: begin
        e.u1 = 1; e.rd = w[11:7]; e.si = 1; e.imm = 32'($signed(w[31:20]));
        alu = base[f3] + ((f3 == 5 && w[30]) ? 1 : 0);
        e.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
      end
      7'h03: begin
        e.u1 = 1; e.rd = w[11:7]; e.si = 1; e.mr = 1; e.msz = f3;
        e.imm = 32'($signed(w[31:20])); e.ill = (f3 == 3 || f3 >= 6);
      end
      7'h23: begin
        e.u1 = 1; e.u2 = 1; e.si = 1; e.mw = 1; e.msz = f3;
        e.imm = 32'($signed({w[31:25], w[11:7]})); e.ill = (f3 > 2);
      end
      7'h63: begin
        e.u1 = 1; e.u2 = 1; e.br = 1; e.bc = f3; alu = 1;
        e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); e.ill = (f3 == 2 || f3 == 3);
      end
      7'h6F: begin
        e.rd = w[11:7]; e.jal = 1; e.sp = 1; e.si = 1;
        e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      end
      7'h67: begin
        e.u1 = 1; e.rd = w[11:7]; e.jalr = 1; e.si = 1;
        e.imm = 32'($signed(w[31:20])); e.ill = (f3 != 0);
      end
      7'h37: begin e.rd = w[11:7]; e.si = 1; e.imm = {w[31:12], 12'h000}; end
      7'h17: begin e.rd = w[11:7]; e.si = 1; e.sp = 1; e.imm = {w[31:12], 12'h000}; end
      default: e.ill = 1;
    endcase
    if (w == 0 || w[1:0] != 2'b11) e.ill = 1;
    e.alu = 5'(alu);
    e.rs1 = e.u1 ? w[19:15] : 5'd0;
    e.rs2 = e.u2 ? w[24:20] : 5'd0;
    e.rw = (e.rd != 0) && !e.ill;
    if (e.ill) begin e.mr = 0; e.mw = 0; e.br = 0; e.jal = 0; e.jalr = 0; end
    return e;
  endfunction

  function automatic logic m_hazard();
    mexp_t e;
    e = ref_decode(instr);
    return in_valid && ex_mem_read && ex_rd != 0 &&
           ((e.u1 && instr[19:15] == ex_rd) || (e.u2 && instr[24:20] == ex_rd));
  endfunction

  logic m_valid, m_zero;
  mexp_t m_b;
  logic [XLEN-1:0] m_pc;
  logic [CNT_W-1:0] m_cnt;

  // Model state advances on the same edge as the DUT, from the stable inputs.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 0; m_zero <= 1; m_b <= '0; m_pc <= '0; m_cnt <= '0;
    end else begin
      if (m_hazard() && m_cnt != {CNT_W{1'b1}}) m_cnt <= m_cnt + 1'b1;
      if (flush) m_valid <= 0;
      else if (in_valid && (!m_valid || out_ready) && !m_hazard()) begin
        m_valid <= 1; m_zero <= 0; m_b <= ref_decode(instr); m_pc <= pc;
      end else if (out_ready) m_valid <= 0;
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model.out_valid", 128'(out_valid), 128'(m_valid));
      check("model.stall_count", 128'(stall_count), 128'(m_cnt));
      check("model.in_ready", 128'(in_ready), 128'((!m_valid || out_ready) && !m_hazard()));
      if (m_valid || m_zero)
        check("model.bundle",
              128'({out_pc, rs1, rs2, rd, imm, alu_op, alu_src_imm, alu_src_pc, mem_read, mem_write,
                    mem_size, reg_write, is_branch, is_jal, is_jalr, branch_cond, illegal}),
              128'({m_pc, m_b.rs1, m_b.rs2, m_b.rd, m_b.imm, m_b.alu, m_b.si, m_b.sp, m_b.mr, m_b.mw,
                    m_b.msz, m_b.rw, m_b.br, m_b.jal, m_b.jalr, m_b.bc, m_b.ill}));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic ordy, input logic fl,
                       input logic emr, input logic [4:0] erd);
    in_valid = v; instr = w; out_ready = ordy; flush = fl; ex_mem_read = emr; ex_rd = erd;
    pc = pc + 32'd4;
  endtask

  logic [31:0] extra [16];

  initial begin
    extra = '{32'h00412303, 32'hFE208EE3, 32'h00001517, 32'h00208033, 32'h000280E7,
              32'h02208133, 32'h0000300B, 32'h000090E7, 32'h0000B083, 32'h0000B023,
              32'h00002063, 32'h00000001, 32'h4020D1B3, 32'h0020F1B3, 32'h00A0A193, 32'h0000C183};
    rst_n = 0; pc = 32'h1000;
    drive(0, 32'h0, 1, 0, 0, 0);
    cyc(); cyc();
    chk_en = 1;
    check("reset.out_valid", 128'(out_valid), 128'd0);
    check("reset.stall", 128'(stall_count), 128'd0);
    check("reset.imm", 128'(imm), 128'd0);
    rst_n = 1;

    drive(1, 32'h002081B3, 1, 0, 0, 0); cyc();
    check("add.valid", 128'(out_valid), 128'd1);
    check("add.regs", 128'({rs1, rs2, rd}), 128'({5'd1, 5'd2, 5'd3}));
    check("add.alu_op", 128'(alu_op), 128'd0);
    check("add.rw_ill", 128'({reg_write, illegal}), 128'b10);

    drive(1, 32'hFFF00293, 1, 0, 0, 0); cyc();
    check("addi.imm", 128'(imm), 128'hFFFFFFFF);
    check("addi.src_alu_rd", 128'({alu_src_imm, alu_op, rd}), 128'({1'b1, 5'd0, 5'd5}));

    drive(1, 32'h00118233, 1, 0, 1, 3); #1;
    check("haz.ready0", 128'(in_ready), 128'd0);
    cyc();
    check("haz.ready1", 128'(in_ready), 128'd0);
    cyc();
    check("haz.count", 128'(stall_count), 128'd2);
    drive(1, 32'h00118233, 1, 0, 0, 3); #1;
    check("haz.release", 128'(in_ready), 128'd1);
    cyc();
    check("haz.accepted", 128'({out_valid, rd, rs1}), 128'({1'b1, 5'd4, 5'd3}));

    drive(1, 32'h40208133, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp.ready", 128'(in_ready), 128'd0);
      check("bp.hold", 128'({out_valid, rd}), 128'({1'b1, 5'd4}));
      cyc();
    end
    drive(1, 32'h40208133, 1, 0, 0, 0); cyc();
    check("bp.new", 128'({rd, alu_op, rs2}), 128'({5'd2, 5'd1, 5'd2}));

    drive(1, 32'h00700393, 0, 1, 0, 0); cyc();
    check("flush.valid", 128'(out_valid), 128'd0);
    drive(0, 32'h0, 1, 0, 0, 0); cyc();
    check("flush.gone", 128'({out_valid, rd}), 128'({1'b0, 5'd2}));

    drive(1, 32'h00000000, 1, 0, 0, 0); cyc();
    check("zero.illegal", 128'({out_valid, illegal, reg_write}), 128'b110);
    drive(1, 32'h008000EF, 1, 0, 0, 0); cyc();
    check("jal.flags", 128'({is_jal, reg_write, rd}), 128'({1'b1, 1'b1, 5'd1}));
    check("jal.imm", 128'(imm), 128'd8);
    drive(1, 32'h123452B7, 1, 0, 1, 8); #1;
    check("lui.nohaz", 128'(in_ready), 128'd1);
    cyc();
    check("lui.imm", 128'(imm), 128'h12345000);
    check("lui.rs1", 128'({rs1, rd}), 128'({5'd0, 5'd5}));
    drive(1, 32'h00612423, 1, 0, 1, 0); #1;
    check("exrd0.nohaz", 128'(in_ready), 128'd1);
    cyc();
    check("sw.ctrl", 128'({mem_write, reg_write, rd, rs1, rs2, mem_size}),
          128'({1'b1, 1'b0, 5'd0, 5'd2, 5'd6, 3'd2}));
    check("sw.imm", 128'(imm), 128'd8);
    drive(1, 32'h4030D093, 1, 0, 0, 0); cyc();
    check("srai.alu", 128'({alu_op, illegal}), 128'({5'd7, 1'b0}));
    drive(1, 32'h40209093, 1, 0, 0, 0); cyc();
    check("slli.bad", 128'({illegal, reg_write}), 128'b10);

    foreach (extra[i]) begin
      drive(1, extra[i], 1, 0, 0, 0); cyc();
    end

    drive(1, 32'h00118233, 0, 0, 1, 3);
    repeat (16) cyc();
    check("sat.count", 128'(stall_count), 128'd15);

    drive(1, 32'h00208033, 1, 0, 0, 0); cyc();
    drive(1, 32'h002081B3, 0, 0, 0, 0); cyc();
    rst_n = 0; cyc();
    check("rst.mid", 128'({out_valid, rd, stall_count}), 128'd0);
    rst_n = 1;
    drive(0, 32'h0, 1, 0, 0, 0); cyc(); cyc();

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
